mc_ctrl_exc: RTL and testbench
==============================

Name: mc_ctrl_exc

Overview:
- Next-generation multicycle MIPS control FSM for the single-memory datapath.
- Adds a parametrised, maskable, prioritised interrupt vector and precise synchronous exceptions for reserved instruction (RI) and overflow (Ov).
- Adds a ready/valid-style stall on data-memory accesses.
- Drives PC, IR, GPR, DM, ALU, ext, CP0 and NPC controls from the registered IR fields.

Parameters:
- N_IRQ, 6: number of hardware interrupt lines, 1..8.
- MEM_HANDSHAKE, 1: 1 = DM states wait for dm_ready; 0 = dm_ready ignored, one cycle per DM state.
- EXC_ON_OVF, 1: 1 = addi overflow raises Ov exception; 0 = addi overflow writes result to $30 (reg_dst=11).
- IRQ_ID_W, 3: width of irq_id, ≥ clog2(N_IRQ).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- opcode  in  6  IR[31:26].
- funct  in  6  IR[5:0].
- rs  in  5  IR[25:21].
- zero  in  1  ALU zero flag.
- overflow  in  1  ALU signed-overflow flag.
- irq  in  N_IRQ  level interrupt requests.
- irq_mask  in  N_IRQ  CP0 SR.IM enables, 1 = enabled.
- exl  in  1  CP0 SR.EXL.
- dm_ready  in  1  DM access complete.
- pc_wr, ir_wr, gpr_wr, dm_wr, dm_rd  out  1  write/read strobes.
- npc_sel  out  3  000 pc+4, 001 j/jal, 010 jr, 011 beq, 100 eret/EPC, 101 exception vector.
- alu_ctr  out  3  000 add, 001 subu, 010 ori, 011 addi, 100 slt, 101 lui.
- reg_dst  out  2  00 rt, 01 rd, 10 $31, 11 $30.
- reg_from_sel  out  2  00 ALU, 01 DM, 10 pc+4, 11 CP0.
- ext_op  out  2  00 zero, 01 sign, 10 lui.
- b_sel  out  1  ALU B source: 1 = imm.
- word_byte_sel  out  1  1 = byte access (lb/sb).
- exl_set, exl_clr, cp0_we  out  1  CP0 controls.
- epc_sel  out  1  0 = EPC←PC (next instruction), 1 = EPC←PC-4 (faulting instruction).
- exc_code  out  5  Cause.ExcCode: 0 Int, 10 RI, 12 Ov.
- irq_id  out  IRQ_ID_W  index of the serviced interrupt line.

Behaviour:
- Decoded instructions: addu subu slt jr addi addiu ori lui lw sw lb sb beq j jal eret mfc0 mtc0. Any other encoding is RI.
- States (4-bit): FETCH, DECODE, MADDR, MRD, MWB, MWR, EXEC, AWB, BR, JMP, INT, EXC, MFC0, MTC0.
- Paths:
  - lw/lb: FETCH→DECODE→MADDR→MRD→MWB.
  - sw/sb: FETCH→DECODE→MADDR→MWR.
  - ALU ops: →EXEC→AWB.
  - beq: →BR.
  - j/jal/jr/eret: →JMP.
  - mfc0: →MFC0.
  - mtc0: →MTC0.
  - RI: DECODE→EXC.
- FETCH: pc_wr=1, ir_wr=1, npc_sel=000.
- MRD: dm_rd=1. If MEM_HANDSHAKE, stay in MRD until dm_ready=1, then go to MWB.
- MWR: dm_wr=1 held each cycle while waiting. Leave on dm_ready=1; dm_wr deasserts the next cycle.
- EXEC with addi, overflow=1 and EXC_ON_OVF=1 → EXC. AWB is skipped, so gpr_wr is never asserted.
- EXC_ON_OVF=0: AWB writes with reg_dst=11 on addi overflow.
- BR: pc_wr = zero.
- JMP: pc_wr=1. jal also asserts gpr_wr with reg_dst=10 and reg_from_sel=10. eret asserts exl_clr with npc_sel=100.
- MFC0: gpr_wr=1, reg_from_sel=11, reg_dst=00.
- MTC0: cp0_we=1.
- Interrupts:
  - pending = |(irq & irq_mask) & ~exl, evaluated in the final state of every instruction (MWB, MWR on exit, AWB, BR, JMP, MFC0, MTC0).
  - pending=1 → INT, else → FETCH. Stalled cycles do not exit and do not sample.
  - Priority: lowest index wins. irq_id is registered on entry to INT and holds until the next INT.
- INT (one cycle): pc_wr=1, npc_sel=101, cp0_we=1, exl_set=1, epc_sel=0, exc_code=0 → FETCH.
- EXC (one cycle): same strobes, but epc_sel=1, exc_code=10 or 12 → FETCH. No interrupt sampling in INT or EXC.
- A synchronous exception always pre-empts a simultaneous interrupt. The interrupt is retaken later only if it is still pending after exl clears.
- In eret's JMP state, the sampled exl is still 1, so no interrupt is taken until the following instruction completes.
- b_sel and ext_op are combinational from opcode, independent of state. All strobes not listed for a state are 0.
- Reset:
  - rst_n=0 asynchronously forces state=FETCH and irq_id=0.
  - While rst_n=0, all write/read strobes (pc_wr, ir_wr, gpr_wr, dm_wr, dm_rd, cp0_we, exl_set, exl_clr) are forced 0, and npc_sel, alu_ctr, reg_dst, reg_from_sel, exc_code and epc_sel are 0.
  - Reset in mid-stall abandons the access with no further dm_wr.

Test Plan:
- addu $3,$1,$2 → DECODE→EXEC→AWB with gpr_wr=1, reg_dst=01, alu_ctr=000, then FETCH; total 4 cycles.
- lw with dm_ready low for 3 cycles (MEM_HANDSHAKE=1) → MRD held 4 cycles with dm_rd=1, then MWB gpr_wr=1 with reg_from_sel=01; lw takes 8 cycles. Same program with MEM_HANDSHAKE=0 → 5 cycles.
- addi with overflow=1: EXC_ON_OVF=1 → no gpr_wr; EXC asserts exc_code=12, epc_sel=1, npc_sel=101, exl_set=1. EXC_ON_OVF=0 → AWB gpr_wr with reg_dst=11.
- opcode 6'b111111 → EXC with exc_code=10 directly after DECODE.
- irq=6'b101000, irq_mask=6'b111000, exl=0 during sw → after MWR: INT, irq_id=3, exc_code=0, epc_sel=0. Same stimulus with exl=1 → FETCH, no INT.
- rst_n pulsed low during MWR stall → dm_wr drops immediately and state=FETCH; after release, the first cycle shows pc_wr=1 and ir_wr=1.

Source files
------------

// File: rtl/mc_ctrl_exc.sv
// rtl/mc_ctrl_exc.sv - multicycle MIPS control FSM with prioritised interrupts, precise exceptions and DM stall
module mc_ctrl_exc #(
  parameter int N_IRQ         = 6,
  parameter int MEM_HANDSHAKE = 1,
  parameter int EXC_ON_OVF    = 1,
  parameter int IRQ_ID_W      = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [5:0]          opcode,
  input  logic [5:0]          funct,
  input  logic [4:0]          rs,
  input  logic                zero,
  input  logic                overflow,
  input  logic [N_IRQ-1:0]    irq,
  input  logic [N_IRQ-1:0]    irq_mask,
  input  logic                exl,
  input  logic                dm_ready,
  output logic                pc_wr,
  output logic                ir_wr,
  output logic                gpr_wr,
  output logic                dm_wr,
  output logic                dm_rd,
  output logic [2:0]          npc_sel,
  output logic [2:0]          alu_ctr,
  output logic [1:0]          reg_dst,
  output logic [1:0]          reg_from_sel,
  output logic [1:0]          ext_op,
  output logic                b_sel,
  output logic                word_byte_sel,
  output logic                exl_set,
  output logic                exl_clr,
  output logic                cp0_we,
  output logic                epc_sel,
  output logic [4:0]          exc_code,
  output logic [IRQ_ID_W-1:0] irq_id
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MADDR  = 4'd2;
  localparam logic [3:0] S_MRD    = 4'd3;
  localparam logic [3:0] S_MWB    = 4'd4;
  localparam logic [3:0] S_MWR    = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_AWB    = 4'd7;
  localparam logic [3:0] S_BR     = 4'd8;
  localparam logic [3:0] S_JMP    = 4'd9;
  localparam logic [3:0] S_INT    = 4'd10;
  localparam logic [3:0] S_EXC    = 4'd11;
  localparam logic [3:0] S_MFC0   = 4'd12;
  localparam logic [3:0] S_MTC0   = 4'd13;

  logic [3:0] state;
  logic [3:0] nxt;
  logic       ovf_q;

  logic r_type, cop0;
  logic i_addu, i_subu, i_slt, i_jr, i_addi, i_addiu, i_ori, i_lui;
  logic i_lw, i_sw, i_lb, i_sb, i_beq, i_j, i_jal, i_eret, i_mfc0, i_mtc0;
  logic is_load, is_store, is_alu, is_jump, is_ri;
  logic [2:0] alu_op;

  assign r_type  = (opcode == 6'b000000);
  assign cop0    = (opcode == 6'b010000);
  assign i_addu  = r_type && (funct == 6'b100001);
  assign i_subu  = r_type && (funct == 6'b100011);
  assign i_slt   = r_type && (funct == 6'b101010);
  assign i_jr    = r_type && (funct == 6'b001000);
  assign i_addi  = (opcode == 6'b001000);
  assign i_addiu = (opcode == 6'b001001);
  assign i_ori   = (opcode == 6'b001101);
  assign i_lui   = (opcode == 6'b001111);
  assign i_lw    = (opcode == 6'b100011);
  assign i_sw    = (opcode == 6'b101011);
  assign i_lb    = (opcode == 6'b100000);
  assign i_sb    = (opcode == 6'b101000);
  assign i_beq   = (opcode == 6'b000100);
  assign i_j     = (opcode == 6'b000010);
  assign i_jal   = (opcode == 6'b000011);
  assign i_eret  = cop0 && (rs == 5'b10000) && (funct == 6'b011000);
  assign i_mfc0  = cop0 && (rs == 5'b00000);
  assign i_mtc0  = cop0 && (rs == 5'b00100);

  assign is_load  = i_lw | i_lb;
  assign is_store = i_sw | i_sb;
  assign is_alu   = i_addu | i_subu | i_slt | i_addi | i_addiu | i_ori | i_lui;
  assign is_jump  = i_j | i_jal | i_jr | i_eret;
  assign is_ri    = ~(is_load | is_store | is_alu | is_jump | i_beq | i_mfc0 | i_mtc0);

  always_comb begin
    alu_op = 3'b000;
    if (i_subu)      alu_op = 3'b001;
    else if (i_ori)  alu_op = 3'b010;
    else if (i_addi) alu_op = 3'b011;
    else if (i_slt)  alu_op = 3'b100;
    else if (i_lui)  alu_op = 3'b101;
  end

  // Operand-shaping controls follow the IR only, so the datapath sees them in every state.
  always_comb begin
    ext_op = 2'b00;
    if (i_addi || i_addiu || is_load || is_store || i_beq) ext_op = 2'b01;
    else if (i_lui)                                        ext_op = 2'b10;
  end

  assign b_sel = i_addi | i_addiu | i_ori | i_lui | is_load | is_store;

  logic [N_IRQ-1:0]    irq_act;
  logic                pending;
  logic [IRQ_ID_W-1:0] irq_pick;
  logic                mem_done;
  logic                ovf_trap;
  logic [3:0]          done_nxt;

  assign irq_act  = irq & irq_mask;
  assign pending  = (|irq_act) & ~exl;
  assign mem_done = (MEM_HANDSHAKE == 0) || dm_ready;
  assign ovf_trap = i_addi && overflow && (EXC_ON_OVF != 0);
  assign done_nxt = pending ? S_INT : S_FETCH;

  // Descending scan so the lowest active line is the last one written.
  always_comb begin
    irq_pick = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (irq_act[i]) irq_pick = IRQ_ID_W'(i);
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      S_FETCH:  nxt = S_DECODE;
      S_DECODE: begin
        if (is_load || is_store) nxt = S_MADDR;
        else if (is_alu)         nxt = S_EXEC;
        else if (i_beq)          nxt = S_BR;
        else if (is_jump)        nxt = S_JMP;
        else if (i_mfc0)         nxt = S_MFC0;
        else if (i_mtc0)         nxt = S_MTC0;
        else                     nxt = S_EXC;
      end
      S_MADDR:  nxt = is_load ? S_MRD : S_MWR;
      S_MRD:    if (mem_done) nxt = S_MWB;
      S_MWR:    if (mem_done) nxt = done_nxt;
      S_EXEC:   nxt = ovf_trap ? S_EXC : S_AWB;
      S_MWB, S_AWB, S_BR, S_JMP, S_MFC0, S_MTC0: nxt = done_nxt;
      S_INT, S_EXC: nxt = S_FETCH;
      default:  nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_FETCH;
      irq_id <= '0;
      ovf_q  <= 1'b0;
    end else begin
      state <= nxt;
      if (nxt == S_INT)    irq_id <= irq_pick;
      if (state == S_EXEC) ovf_q  <= overflow;
    end
  end

  // Strobes are gated by rst_n directly so an abandoned access stops without waiting for a clock.
  always_comb begin
    pc_wr         = 1'b0;
    ir_wr         = 1'b0;
    gpr_wr        = 1'b0;
    dm_wr         = 1'b0;
    dm_rd         = 1'b0;
    npc_sel       = 3'b000;
    alu_ctr       = 3'b000;
    reg_dst       = 2'b00;
    reg_from_sel  = 2'b00;
    word_byte_sel = 1'b0;
    exl_set       = 1'b0;
    exl_clr       = 1'b0;
    cp0_we        = 1'b0;
    epc_sel       = 1'b0;
    exc_code      = 5'd0;
    if (rst_n) begin
      case (state)
        S_FETCH: begin
          pc_wr = 1'b1;
          ir_wr = 1'b1;
        end
        S_MADDR: word_byte_sel = i_lb | i_sb;
        S_MRD: begin
          dm_rd         = 1'b1;
          word_byte_sel = i_lb | i_sb;
        end
        S_MWB: begin
          gpr_wr        = 1'b1;
          reg_from_sel  = 2'b01;
          word_byte_sel = i_lb | i_sb;
        end
        S_MWR: begin
          dm_wr         = 1'b1;
          word_byte_sel = i_lb | i_sb;
        end
        S_EXEC: alu_ctr = alu_op;
        S_AWB: begin
          alu_ctr = alu_op;
          gpr_wr  = 1'b1;
          if (r_type)                      reg_dst = 2'b01;
          else if (i_addi && ovf_q)        reg_dst = 2'b11;
        end
        S_BR: begin
          alu_ctr = 3'b001;
          npc_sel = 3'b011;
          pc_wr   = zero;
        end
        S_JMP: begin
          pc_wr = 1'b1;
          if (i_jr)        npc_sel = 3'b010;
          else if (i_eret) npc_sel = 3'b100;
          else             npc_sel = 3'b001;
          if (i_jal) begin
            gpr_wr       = 1'b1;
            reg_dst      = 2'b10;
            reg_from_sel = 2'b10;
          end
          exl_clr = i_eret;
        end
        S_MFC0: begin
          gpr_wr       = 1'b1;
          reg_from_sel = 2'b11;
        end
        S_MTC0: cp0_we = 1'b1;
        S_INT: begin
          pc_wr   = 1'b1;
          npc_sel = 3'b101;
          cp0_we  = 1'b1;
          exl_set = 1'b1;
        end
        S_EXC: begin
          pc_wr    = 1'b1;
          npc_sel  = 3'b101;
          cp0_we   = 1'b1;
          exl_set  = 1'b1;
          epc_sel  = 1'b1;
          exc_code = is_ri ? 5'd10 : 5'd12;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_ctrl_exc.sv
// tb/tb_mc_ctrl_exc.sv - scoreboard bench for mc_ctrl_exc, two parameter sets driven from randomized programs
module tb_mc_ctrl_exc;
  localparam int NI = 6;
  localparam int IW = 3;

  localparam int C_ADDU = 0,  C_SUBU = 1,  C_SLT = 2,  C_JR = 3,   C_ADDI = 4;
  localparam int C_ADDIU = 5, C_ORI = 6,   C_LUI = 7,  C_LW = 8,   C_SW = 9;
  localparam int C_LB = 10,   C_SB = 11,   C_BEQ = 12, C_J = 13,   C_JAL = 14;
  localparam int C_ERET = 15, C_MFC0 = 16, C_MTC0 = 17, C_RI = 18;

  typedef struct packed {
    logic          pc_wr;
    logic          ir_wr;
    logic          gpr_wr;
    logic          dm_wr;
    logic          dm_rd;
    logic [2:0]    npc_sel;
    logic [2:0]    alu_ctr;
    logic [1:0]    reg_dst;
    logic [1:0]    reg_from_sel;
    logic [1:0]    ext_op;
    logic          b_sel;
    logic          word_byte_sel;
    logic          exl_set;
    logic          exl_clr;
    logic          cp0_we;
    logic          epc_sel;
    logic [4:0]    exc_code;
    logic [IW-1:0] irq_id;
  } out_t;

  logic          clk;
  logic          rst_n;
  logic [5:0]    opcode   [2];
  logic [5:0]    funct    [2];
  logic [4:0]    rs       [2];
  logic          zero     [2];
  logic          overflow [2];
  logic [NI-1:0] irq      [2];
  logic [NI-1:0] irq_mask [2];
  logic          exl      [2];
  logic          dm_ready [2];
  out_t          obs      [2];

  out_t q0[$];
  out_t q1[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   prev_cls [2];
  int   model_id [2];

  // dut[0]: handshake on, overflow traps. dut[1]: handshake off, overflow writes $30.
  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic pc_wr, ir_wr, gpr_wr, dm_wr, dm_rd, b_sel, word_byte_sel;
    logic exl_set, exl_clr, cp0_we, epc_sel;
    logic [2:0] npc_sel, alu_ctr;
    logic [1:0] reg_dst, reg_from_sel, ext_op;
    logic [4:0] exc_code;
    logic [IW-1:0] irq_id;
    mc_ctrl_exc #(
      .N_IRQ(NI), .MEM_HANDSHAKE((g == 0) ? 1 : 0), .EXC_ON_OVF((g == 0) ? 1 : 0), .IRQ_ID_W(IW)
    ) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode[g]), .funct(funct[g]), .rs(rs[g]),
      .zero(zero[g]), .overflow(overflow[g]), .irq(irq[g]), .irq_mask(irq_mask[g]),
      .exl(exl[g]), .dm_ready(dm_ready[g]),
      .pc_wr(pc_wr), .ir_wr(ir_wr), .gpr_wr(gpr_wr), .dm_wr(dm_wr), .dm_rd(dm_rd),
      .npc_sel(npc_sel), .alu_ctr(alu_ctr), .reg_dst(reg_dst), .reg_from_sel(reg_from_sel),
      .ext_op(ext_op), .b_sel(b_sel), .word_byte_sel(word_byte_sel), .exl_set(exl_set),
      .exl_clr(exl_clr), .cp0_we(cp0_we), .epc_sel(epc_sel), .exc_code(exc_code), .irq_id(irq_id)
    );
    assign obs[g] = {pc_wr, ir_wr, gpr_wr, dm_wr, dm_rd, npc_sel, alu_ctr, reg_dst, reg_from_sel,
                     ext_op, b_sel, word_byte_sel, exl_set, exl_clr, cp0_we, epc_sel, exc_code, irq_id};
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk_out(input string name, input out_t act, input out_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d want %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q0.size() != 0) chk_out("dut0_cycle", obs[0], q0.pop_front());
    if (q1.size() != 0) chk_out("dut1_cycle", obs[1], q1.pop_front());
  end

  function automatic logic [1:0] ext_of(input int c);
    if (c == C_ADDI || c == C_ADDIU || c == C_LW || c == C_SW || c == C_LB || c == C_SB || c == C_BEQ)
      return 2'b01;
    if (c == C_LUI) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic bsel_of(input int c);
    return (c == C_ADDI || c == C_ADDIU || c == C_ORI || c == C_LUI ||
            c == C_LW || c == C_SW || c == C_LB || c == C_SB);
  endfunction

  function automatic logic [2:0] alu_of(input int c);
    case (c)
      C_SUBU:  return 3'd1;
      C_ORI:   return 3'd2;
      C_ADDI:  return 3'd3;
      C_SLT:   return 3'd4;
      C_LUI:   return 3'd5;
      default: return 3'd0;
    endcase
  endfunction

  function automatic out_t blank(input int c, input int d);
    out_t e;
    e = '0;
    e.ext_op = ext_of(c);
    e.b_sel  = bsel_of(c);
    e.irq_id = IW'(model_id[d]);
    return e;
  endfunction

  function automatic out_t trap(input int c, input int d, input logic [4:0] code, input logic faulting);
    out_t e;
    e = blank(c, d);
    e.pc_wr = 1'b1;
    e.npc_sel = 3'b101;
    e.cp0_we = 1'b1;
    e.exl_set = 1'b1;
    e.epc_sel = faulting;
    e.exc_code = code;
    return e;
  endfunction

  task automatic encode(input int c, input int ri, output logic [5:0] op, output logic [5:0] fn,
                        output logic [4:0] r);
    op = 6'd0;
    fn = 6'($urandom);
    r  = 5'($urandom);
    case (c)
      C_ADDU:  fn = 6'b100001;
      C_SUBU:  fn = 6'b100011;
      C_SLT:   fn = 6'b101010;
      C_JR:    fn = 6'b001000;
      C_ADDI:  op = 6'b001000;
      C_ADDIU: op = 6'b001001;
      C_ORI:   op = 6'b001101;
      C_LUI:   op = 6'b001111;
      C_LW:    op = 6'b100011;
      C_SW:    op = 6'b101011;
      C_LB:    op = 6'b100000;
      C_SB:    op = 6'b101000;
      C_BEQ:   op = 6'b000100;
      C_J:     op = 6'b000010;
      C_JAL:   op = 6'b000011;
      C_ERET:  begin op = 6'b010000; r = 5'b10000; fn = 6'b011000; end
      C_MFC0:  begin op = 6'b010000; r = 5'b00000; end
      C_MTC0:  begin op = 6'b010000; r = 5'b00100; end
      default: begin
        case (ri)
          0:       op = 6'b111111;
          1:       fn = 6'b000000;
          2:       op = 6'b010001;
          3:       begin op = 6'b010000; r = 5'b00001; end
          default: op = 6'b000101;
        endcase
      end
    endcase
  endtask

  // Builds the whole expected cycle trace of one instruction, queues it, then plays the inputs.
  task automatic run_instr(input int d, input int c, input int ri, input int w, input bit ov,
                           input bit zr, input logic [NI-1:0] iv, input logic [NI-1:0] mv, input bit xv);
    out_t eq[$];
    bit   dq[$];
    out_t e;
    bit   hs, trap_ov, fin;
    int   id;
    logic [5:0] op, fn;
    logic [4:0] r;
    hs = (d == 0);
    trap_ov = (d == 0);
    fin = 1'b1;
    encode(c, ri, op, fn, r);
    e = blank(prev_cls[d], d); e.pc_wr = 1'b1; e.ir_wr = 1'b1;
    eq.push_back(e); dq.push_back(1'b0);
    e = blank(c, d);
    eq.push_back(e); dq.push_back(1'b0);
    case (c)
      C_LW, C_LB, C_SW, C_SB: begin
        e = blank(c, d); e.word_byte_sel = (c == C_LB || c == C_SB);
        eq.push_back(e); dq.push_back(1'b0);
        for (int k = 0; k <= (hs ? w : 0); k++) begin
          if (c == C_LW || c == C_LB) e.dm_rd = 1'b1; else e.dm_wr = 1'b1;
          eq.push_back(e); dq.push_back(hs && (k == w));
        end
        if (c == C_LW || c == C_LB) begin
          e.dm_rd = 1'b0; e.gpr_wr = 1'b1; e.reg_from_sel = 2'b01;
          eq.push_back(e); dq.push_back(1'b0);
        end
      end
      C_ADDU, C_SUBU, C_SLT, C_ADDI, C_ADDIU, C_ORI, C_LUI: begin
        e = blank(c, d); e.alu_ctr = alu_of(c);
        eq.push_back(e); dq.push_back(1'b0);
        if (c == C_ADDI && ov && trap_ov) begin
          eq.push_back(trap(c, d, 5'd12, 1'b1)); dq.push_back(1'b0);
          fin = 1'b0;
        end else begin
          e.gpr_wr = 1'b1;
          if (c == C_ADDU || c == C_SUBU || c == C_SLT) e.reg_dst = 2'b01;
          else if (c == C_ADDI && ov)                   e.reg_dst = 2'b11;
          eq.push_back(e); dq.push_back(1'b0);
        end
      end
      C_BEQ: begin
        e = blank(c, d); e.alu_ctr = 3'd1; e.npc_sel = 3'b011; e.pc_wr = zr;
        eq.push_back(e); dq.push_back(1'b0);
      end
      C_J, C_JAL, C_JR, C_ERET: begin
        e = blank(c, d); e.pc_wr = 1'b1;
        e.npc_sel = (c == C_JR) ? 3'b010 : (c == C_ERET) ? 3'b100 : 3'b001;
        if (c == C_JAL) begin e.gpr_wr = 1'b1; e.reg_dst = 2'b10; e.reg_from_sel = 2'b10; end
        e.exl_clr = (c == C_ERET);
        eq.push_back(e); dq.push_back(1'b0);
      end
      C_MFC0: begin
        e = blank(c, d); e.gpr_wr = 1'b1; e.reg_from_sel = 2'b11;
        eq.push_back(e); dq.push_back(1'b0);
      end
      C_MTC0: begin
        e = blank(c, d); e.cp0_we = 1'b1;
        eq.push_back(e); dq.push_back(1'b0);
      end
      default: begin
        eq.push_back(trap(c, d, 5'd10, 1'b1)); dq.push_back(1'b0);
        fin = 1'b0;
      end
    endcase
    if (fin && ((iv & mv) != '0) && !xv) begin
      id = 0;
      while (!iv[id] || !mv[id]) id++;
      model_id[d] = id;
      eq.push_back(trap(c, d, 5'd0, 1'b0)); dq.push_back(1'b0);
    end
    foreach (eq[i]) begin
      if (d == 0) q0.push_back(eq[i]); else q1.push_back(eq[i]);
    end
    for (int i = 0; i < eq.size(); i++) begin
      if (i == 1) begin opcode[d] = op; funct[d] = fn; rs[d] = r; end
      dm_ready[d] = dq[i]; overflow[d] = ov; zero[d] = zr;
      irq[d] = iv; irq_mask[d] = mv; exl[d] = xv;
      @(posedge clk); #1;
    end
    prev_cls[d] = c;
  endtask

  task automatic run_prog(input int d);
    run_instr(d, C_ADDU, 0, 0, 0, 0, '0, '0, 0);
    run_instr(d, C_LW,   0, 3, 0, 0, '0, '0, 0);
    run_instr(d, C_ADDI, 0, 0, 1, 0, '0, '0, 0);
    run_instr(d, C_ADDI, 0, 0, 0, 0, '0, '0, 0);
    run_instr(d, C_RI,   0, 0, 0, 0, '0, '0, 0);
    run_instr(d, C_SW,   0, 2, 0, 0, 6'b101000, 6'b111000, 0);
    run_instr(d, C_SW,   0, 2, 0, 0, 6'b101000, 6'b111000, 1);
    run_instr(d, C_BEQ,  0, 0, 0, 1, '0, '0, 0);
    run_instr(d, C_ERET, 0, 0, 0, 0, 6'b000001, 6'b000001, 1);
    for (int n = 0; n < 200; n++) begin
      run_instr(d, $urandom_range(0, 18), $urandom_range(0, 4), $urandom_range(0, 3),
                1'($urandom), 1'($urandom),
                ($urandom_range(0, 2) == 0) ? NI'($urandom) : '0, NI'($urandom),
                $urandom_range(0, 3) == 0);
    end
  endtask

  initial begin
    out_t z;
    logic [5:0] op, fn;
    logic [4:0] r;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      opcode[d] = '0; funct[d] = '0; rs[d] = '0; zero[d] = 0; overflow[d] = 0;
      irq[d] = '0; irq_mask[d] = '0; exl[d] = 0; dm_ready[d] = 0;
      prev_cls[d] = C_RI; model_id[d] = 0;
    end
    repeat (3) @(posedge clk);
    #2;
    chk_out("reset_dut0", obs[0], '0);
    chk_out("reset_dut1", obs[1], '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    fork
      run_prog(0);
      run_prog(1);
    join
    chk_int("q0_drained", q0.size(), 0);
    chk_int("q1_drained", q1.size(), 0);

    encode(C_SW, 0, op, fn, r);
    opcode[0] = op; funct[0] = fn; rs[0] = r;
    irq[0] = '0; dm_ready[0] = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk_int("stall_dm_wr", int'(obs[0].dm_wr), 1);
    @(posedge clk); #1;
    chk_int("stall_dm_wr_held", int'(obs[0].dm_wr), 1);
    #3 rst_n = 1'b0;
    #1;
    z = '0; z.ext_op = 2'b01; z.b_sel = 1'b1;
    chk_out("midstall_reset", obs[0], z);
    @(posedge clk); #1;
    chk_out("reset_held", obs[0], z);
    rst_n = 1'b1;
    #1;
    chk_int("post_reset_pc_wr", int'(obs[0].pc_wr), 1);
    chk_int("post_reset_ir_wr", int'(obs[0].ir_wr), 1);
    @(posedge clk); #1;
    chk_int("post_reset_decode_dm_wr", int'(obs[0].dm_wr), 0);
    chk_int("post_reset_decode_pc_wr", int'(obs[0].pc_wr), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
